ram_responder: RTL and testbench

- Memory-side responder that serves the word read and write-through requests a cache issues towards main memory.
- Accepts one request at a time over a valid/ready request channel and holds storage of DEPTH words.
- Returns a response after a fixed, parameterised latency over a valid/ready response channel with backpressure.
- Sits between the cache controller and the backing storage, modelling a slow RAM.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_array.sv | 27 ++
 rtl/ram_responder.sv | 155 +++++++++++++++
 tb/tb_ram_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and width helpers for the ram_responder slow-RAM model.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/ram_array.sv
// DEPTH x DATA_W word storage: clocked write port, combinational read port.
module ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately left out of reset so it maps onto RAM macros;
    // contents stay undefined until written and survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_index] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_index];

endmodule

// File: rtl/ram_responder.sv
// Fixed-latency memory responder with valid/ready request and response channels.
// Optional out-of-range error reporting when RAM_RESPONDER_ERR_EN is defined.
module ram_responder
    import ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_write,
    output logic              resp_error
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_write_q, resp_write_d;
    logic              resp_error_q, resp_error_d;

    logic              accept;
    logic              out_of_range;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

`ifdef RAM_RESPONDER_ERR_EN
    assign out_of_range = (req_address >= ADDR_W'(DEPTH));
`else
    logic unused_addr_hi;
    assign out_of_range   = 1'b0;
    assign unused_addr_hi = ^req_address[ADDR_W-1:IDX_W];
`endif

    assign accept = req_valid && (state_q == IDLE);
    assign wr_en  = accept && req_write && !out_of_range;

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock    (clock),
        .wr_en    (wr_en),
        .wr_index (req_address[IDX_W-1:0]),
        .wr_data  (req_data),
        .rd_index (index_q),
        .rd_data  (rd_data)
    );

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_write_d = resp_write_q;
        resp_error_d = resp_error_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    wdata_d = req_data;
                    index_d = req_address[IDX_W-1:0];
                    err_d   = out_of_range;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // First edge in RESP loads the response; it is presented from then on.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_write_d = write_q;
                    resp_error_d = err_q;
                    resp_data_d  = err_q ? '0 : (write_q ? wdata_q : rd_data);
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            index_q      <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_write_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            index_q      <= index_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_write_q <= resp_write_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_write = resp_write_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=1 instance for back-to-back throughput.
module tb_ram_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
`ifdef RAM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        write;
        logic        err;
        int          accept_cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_write, resp_error;
    logic [31:0] req_address, req_data, resp_data;
    logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_write1, resp_error1;
    logic [31:0] req_address1, req_data1, resp_data1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t cur0, cur1;
    bit   act0 = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .LATENCY(LAT0)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_write(resp_write), .resp_error(resp_error)
    );

    ram_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .LATENCY(LAT1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_address(req_address1), .req_data(req_data1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1),
        .resp_write(resp_write1), .resp_error(resp_error1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the LATENCY=2 instance: first cycle checks content and latency,
    // later cycles of the same response check that it holds stable.
    always @(negedge clock) begin
        if (!reset_n) begin
            act0 = 1'b0;
        end else if (resp_valid) begin
            if (!act0) begin
                if (q0.size() == 0) begin
                    check("unexpected_resp", resp_valid, 1'b0);
                end else begin
                    cur0 = q0.pop_front();
                    act0 = 1'b1;
                    check("resp_data", resp_data, cur0.data);
                    check("resp_write", resp_write, cur0.write);
                    check("resp_error", resp_error, cur0.err);
                    check("latency", cyc - cur0.accept_cyc, LAT0);
                end
            end else begin
                check("hold_data", resp_data, cur0.data);
                check("hold_write", resp_write, cur0.write);
                check("hold_error", resp_error, cur0.err);
            end
            if (resp_ready) act0 = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (reset_n && resp_valid1) begin
            if (q1.size() == 0) begin
                check("unexpected_resp1", resp_valid1, 1'b0);
            end else begin
                cur1 = q1.pop_front();
                check("resp1_data", resp_data1, cur1.data);
                check("resp1_write", resp_write1, cur1.write);
                check("resp1_error", resp_error1, cur1.err);
                check("latency1", cyc - cur1.accept_cyc, LAT1);
            end
        end
    end

    task automatic send0(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_data, input logic exp_err, input bit push);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = w; req_address = addr; req_data = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", req_ready, 1'b1);
        e.data = exp_data; e.write = w; e.err = exp_err; e.accept_cyc = cyc + 1;
        if (push) q0.push_back(e);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain0();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock); #1;
            if (q0.size() == 0 && !act0) begin ok = 1'b1; break; end
        end
        if (!ok) check("drain_timeout", q0.size(), 0);
        @(negedge clock);
        check("req_ready_after_resp", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic        w1 [5];
        logic [31:0] a1 [5];
        logic [31:0] d1 [5];
        logic [31:0] e1 [5];
        logic        r1 [5];
        int          prev_acc;
        exp_t        e;
        bit          ok;

        reset_n = 1'b0;
        req_valid = 0; req_write = 0; req_address = 0; req_data = 0; resp_ready = 1;
        req_valid1 = 0; req_write1 = 0; req_address1 = 0; req_data1 = 0; resp_ready1 = 1;
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_write", resp_write, 1'b0);
        check("rst_resp_error", resp_error, 1'b0);
        @(negedge clock); reset_n = 1'b1;

        // Write then read back the same word.
        send0(1'b1, 32'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
        drain0();
        send0(1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drain0();

        // Backpressure: response must hold and no new request may be taken.
        resp_ready = 1'b0;
        send0(1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            req_valid = 1'b1; req_write = 1'b1; req_address = 32'd5; req_data = 32'h0BAD0BAD;
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_resp_valid", resp_valid, 1'b1);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        drain0();

        // Address 37 aliases to 5 unless out-of-range errors are enabled.
        send0(1'b1, 32'd37, 32'h1234, ERR_EN ? 32'h0 : 32'h1234, ERR_EN, 1'b1);
        drain0();
        send0(1'b0, 32'd5, 32'h0, ERR_EN ? 32'hDEADBEEF : 32'h1234, 1'b0, 1'b1);
        drain0();

        // Reset during WAIT drops the read but keeps committed writes.
        send0(1'b1, 32'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b1);
        drain0();
        send0(1'b0, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_resp_valid", resp_valid, 1'b0);
        @(negedge clock); reset_n = 1'b1;
        #1;
        check("postrst_req_ready", req_ready, 1'b1);
        check("postrst_resp_valid", resp_valid, 1'b0);
        check("postrst_resp_data", resp_data, 32'h0);
        send0(1'b0, 32'd3, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
        drain0();

        // LATENCY=1 instance: requests held back-to-back, one accepted every 3 cycles.
        w1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        a1 = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd33};
        d1 = '{32'h11, 32'h22, 32'h0, 32'h0, 32'h0};
        e1 = '{32'h11, 32'h22, 32'h11, 32'h22, ERR_EN ? 32'h0 : 32'h11};
        r1 = '{1'b0, 1'b0, 1'b0, 1'b0, ERR_EN};
        prev_acc = 0;
        @(posedge clock); #1;
        req_valid1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_write1 = w1[k]; req_address1 = a1[k]; req_data1 = d1[k];
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (req_ready1) begin ok = 1'b1; break; end
            end
            if (!ok) check("accept1_timeout", req_ready1, 1'b1);
            e.data = e1[k]; e.write = w1[k]; e.err = r1[k]; e.accept_cyc = cyc + 1;
            q1.push_back(e);
            if (k > 0) check("accept1_interval", e.accept_cyc - prev_acc, 3);
            prev_acc = e.accept_cyc;
            @(posedge clock); #1;
        end
        req_valid1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #1;
            if (q1.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("drain1_timeout", q1.size(), 0);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
